flush_ctrl: RTL

Pipeline flush and fetch-redirect controller. Sits beside the write-back stage and turns its exception and exception-return indications (`wb_ex`, `ertn_flush`) into three things: a same-cycle flush to every stage, a drain of instruction-fetch responses still in flight, and a single redirect handshake to pre-IF carrying the new PC (`csr_eentry` for an exception, `csr_era` for `ertn`). It also keeps a flush event counter for debug.

---
 rtl/flush_ctrl_pkg.sv | 13 +
 rtl/inflight_cnt.sv | 33 +++
 rtl/flush_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/flush_ctrl_pkg.sv
// flush_ctrl shared types
// FSM state encodings, also used by fetch-stage assertions
package flush_ctrl_pkg;

    typedef enum logic [1:0] {
        FC_IDLE     = 2'd0,
        FC_DRAIN    = 2'd1,
        FC_REDIRECT = 2'd2
    } fc_state_e;

    localparam int PC_W = 32;

endpackage

// File: rtl/inflight_cnt.sv
// inflight_cnt: outstanding instruction request counter
// +1 per accepted request, -1 per returned response
module inflight_cnt
    import flush_ctrl_pkg::*;
#(
    parameter int OUTST_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req_fire,
    input  logic               inst_data_ok,
    output logic [OUTST_W-1:0] cnt,
    output logic [OUTST_W-1:0] cnt_next
);

    // next count; fire and response together cancel
    always_comb begin
        cnt_next = cnt;
        if (inst_req_fire && !inst_data_ok)
            cnt_next = cnt + OUTST_W'(1);
        else if (!inst_req_fire && inst_data_ok)
            cnt_next = cnt - OUTST_W'(1);
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= cnt_next;
    end

endmodule

// File: rtl/flush_ctrl.sv
// flush_ctrl: WB-driven pipeline flush and fetch redirect
// drains stale fetch responses, then hands pre-IF the new PC
module flush_ctrl
    import flush_ctrl_pkg::*;
#(
    parameter int OUTST_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_ex,
    input  logic            ertn_flush,
    input  logic [PC_W-1:0] csr_eentry,
    input  logic [PC_W-1:0] csr_era,
    input  logic            inst_req_fire,
    input  logic            inst_data_ok,
    output logic            flush,
    output logic            fetch_stall,
    output logic            inst_discard,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic [31:0]     flush_cnt
);

    fc_state_e          state_q;
    fc_state_e          state_d;
    logic [OUTST_W-1:0] dcnt_q;
    logic [OUTST_W-1:0] dcnt_d;
    logic [OUTST_W-1:0] cnt;
    logic [OUTST_W-1:0] cnt_next;
    logic [PC_W-1:0]    tgt_q;
    logic [31:0]        fcnt_q;
    logic               trig;

    assign trig           = (wb_ex | ertn_flush) & ~reset;
    assign flush          = trig;
    assign redirect_pc    = tgt_q;
    assign flush_cnt      = fcnt_q;

    inflight_cnt #(
        .OUTST_W (OUTST_W)
    ) u_cnt (
        .clk           (clk),
        .reset         (reset),
        .inst_req_fire (inst_req_fire),
        .inst_data_ok  (inst_data_ok),
        .cnt           (cnt),
        .cnt_next      (cnt_next)
    );

    // next state and handshake outputs; a trigger overrides everything
    always_comb begin
        state_d        = state_q;
        dcnt_d         = dcnt_q;
        fetch_stall    = 1'b0;
        inst_discard   = 1'b0;
        redirect_valid = 1'b0;
        unique case (state_q)
            FC_IDLE: begin
            end
            FC_DRAIN: begin
                fetch_stall  = 1'b1;
                inst_discard = inst_data_ok;
                if (inst_data_ok) begin
                    dcnt_d = dcnt_q - OUTST_W'(1);
                    if (dcnt_q == OUTST_W'(1))
                        state_d = FC_REDIRECT;
                end else if (dcnt_q == '0) begin
                    state_d = FC_REDIRECT;
                end
            end
            FC_REDIRECT: begin
                fetch_stall    = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready)
                    state_d = FC_IDLE;
            end
            default: state_d = FC_IDLE;
        endcase
        if (trig) begin
            dcnt_d  = cnt_next;
            state_d = (cnt_next != '0) ? FC_DRAIN : FC_REDIRECT;
        end
    end

    // state, discard count, target latch and event counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FC_IDLE;
            dcnt_q  <= '0;
            tgt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (trig) begin
                tgt_q  <= wb_ex ? csr_eentry : csr_era;
                fcnt_q <= fcnt_q + 32'd1;
            end
        end
    end

endmodule
